// File: rtl/bus_arbiter_rr_pkg.sv
// Shared definitions for the system-bus round-robin arbiter: FSM state
// encodings, a constant-function clog2 and the default begin timeout that
// the ramDmaCi benches reuse.
package bus_arb_pkg;

   typedef enum logic [2:0] {
      IDLE       = 3'd0,
      GRANT      = 3'd1,
      WAIT_BEGIN = 3'd2,
      BUSY       = 3'd3,
      ABORT      = 3'd4
   } arbState_e;

   // Cycles a granted master gets to start its transaction.
   localparam int DEFAULT_TIMEOUT = 16;

   // Ceiling log2; returns 0 for values of 0 or 1.
   function automatic int clog2(input int value);
      int result;
      result = 0;
      while ((32'd1 << result) < value) begin
         result = result + 32'sd1;
      end
      return result;
   endfunction

   function automatic int maxInt(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/bus_arbiter_rr_if.sv
// Bus-arbitration handshake bundle. The slave modport is the arbiter's view,
// the master modport is the view of the requesters and the shared bus lines.
interface bus_arbiter_rr_if
   import bus_arb_pkg::*;
#(
   parameter int NUM_MASTERS = 4,
   parameter int OWNER_W     = clog2(NUM_MASTERS)
);

   logic [NUM_MASTERS-1:0] requestTransaction;
   logic [NUM_MASTERS-1:0] transactionGranted;
   logic                   beginTransactionIn;
   logic                   endTransactionIn;
   logic                   busErrorIn;
   logic                   endTransactionOut;
   logic                   busErrorOut;
   logic [OWNER_W-1:0]     busOwner;
   logic                   busActive;

   modport slave (
      input  requestTransaction, beginTransactionIn, endTransactionIn, busErrorIn,
      output transactionGranted, endTransactionOut, busErrorOut, busOwner, busActive
   );

   modport master (
      output requestTransaction, beginTransactionIn, endTransactionIn, busErrorIn,
      input  transactionGranted, endTransactionOut, busErrorOut, busOwner, busActive
   );

endinterface

// File: rtl/bus_arbiter_rr_pick.sv
// Combinational round-robin picker: rotates the request vector so the bit
// after the pointer sits at position 0, takes the lowest set bit, and maps
// that offset back to an absolute master index.
module rr_pick #(
   parameter int NUM_MASTERS = 4,
   parameter int IDX_W       = 2
) (
   input  logic [NUM_MASTERS-1:0] request,
   input  logic [IDX_W-1:0]       pointer,
   output logic [IDX_W-1:0]       winner,
   output logic                   valid
);

   logic [2*NUM_MASTERS-1:0] doubled_s;
   logic [NUM_MASTERS-1:0]   rotated_s;
   int                       startIdx_s;
   int                       firstSet_s;
   int                       absIdx_s;

   // Rotate, priority-encode from the bottom, then unrotate.
   always_comb begin
      startIdx_s = (int'(pointer) + 32'sd1) % NUM_MASTERS;
      doubled_s  = {request, request};
      rotated_s  = NUM_MASTERS'(doubled_s >> startIdx_s);
      firstSet_s = 32'sd0;
      for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
         firstSet_s = rotated_s[i] ? i : firstSet_s;
      end
      absIdx_s = (startIdx_s + firstSet_s) % NUM_MASTERS;
      winner   = IDX_W'(absIdx_s);
      valid    = |request;
   end

endmodule

// File: rtl/bus_arbiter_rr.sv
// Round-robin arbiter for the shared system bus. Grants one master at a
// time with a single-cycle pulse, follows that master's begin/end strobes,
// withdraws a grant that is never used, and aborts hung transactions with a
// forced end plus bus error.
module bus_arbiter_rr
   import bus_arb_pkg::*;
#(
   parameter int NUM_MASTERS     = 4,
   parameter int BEGIN_TIMEOUT   = 16,
   parameter int WATCHDOG_CYCLES = 256
) (
   input logic             clock,
   input logic             reset,
   bus_arbiter_rr_if.slave bus
);

   localparam int OWNER_W = clog2(NUM_MASTERS);
   localparam int CNT_W   = clog2(maxInt(BEGIN_TIMEOUT, WATCHDOG_CYCLES)) + 1;

   localparam logic [2:0] ST_IDLE       = 3'(IDLE);
   localparam logic [2:0] ST_GRANT      = 3'(GRANT);
   localparam logic [2:0] ST_WAIT_BEGIN = 3'(WAIT_BEGIN);
   localparam logic [2:0] ST_BUSY       = 3'(BUSY);
   localparam logic [2:0] ST_ABORT      = 3'(ABORT);

   localparam logic [CNT_W-1:0]       CNT_ZERO    = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0]       CNT_ONE     = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0]       CNT_MAX     = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0]       BEGIN_LIMIT = CNT_W'(BEGIN_TIMEOUT - 1);
   localparam logic [CNT_W-1:0]       WD_LIMIT    = CNT_W'(WATCHDOG_CYCLES - 1);
   localparam logic [NUM_MASTERS-1:0] GRANT_NONE  = {NUM_MASTERS{1'b0}};
   localparam logic [NUM_MASTERS-1:0] GRANT_LSB   = {{(NUM_MASTERS-1){1'b0}}, 1'b1};
   localparam logic [OWNER_W-1:0]     OWNER_ZERO  = {OWNER_W{1'b0}};
   localparam logic [OWNER_W-1:0]     PTR_RESET   = OWNER_W'(NUM_MASTERS - 1);

   logic [2:0]             state_r;
   logic [2:0]             stateNext_s;
   logic [CNT_W-1:0]       cnt_r;
   logic [CNT_W-1:0]       cntNext_s;
   logic [CNT_W-1:0]       cntInc_s;
   logic [OWNER_W-1:0]     pointer_r;
   logic [OWNER_W-1:0]     pointerNext_s;
   logic [OWNER_W-1:0]     busOwner_r;
   logic [OWNER_W-1:0]     ownerNext_s;
   logic [NUM_MASTERS-1:0] grant_r;
   logic [NUM_MASTERS-1:0] grantNext_s;
   logic                   forceEnd_r;
   logic                   forceErr_r;
   logic                   busActive_r;
   logic [OWNER_W-1:0]     pickWinner_s;
   logic                   pickValid_s;
   logic                   ownerReq_s;

   rr_pick #(
      .NUM_MASTERS (NUM_MASTERS),
      .IDX_W       (OWNER_W)
   ) u_pick (
      .request (bus.requestTransaction),
      .pointer (pointer_r),
      .winner  (pickWinner_s),
      .valid   (pickValid_s)
   );

   assign ownerReq_s = bus.requestTransaction[busOwner_r];
   assign cntInc_s   = (cnt_r == CNT_MAX) ? cnt_r : (cnt_r + CNT_ONE);

   // Next-state, counter, pointer and grant decode for the arbitration FSM.
   always_comb begin
      stateNext_s   = state_r;
      cntNext_s     = cnt_r;
      pointerNext_s = pointer_r;
      ownerNext_s   = busOwner_r;
      grantNext_s   = GRANT_NONE;
      case (state_r)
         ST_IDLE: begin
            cntNext_s = CNT_ZERO;
            if (pickValid_s) begin
               stateNext_s   = ST_GRANT;
               pointerNext_s = pickWinner_s;
               ownerNext_s   = pickWinner_s;
               grantNext_s   = GRANT_LSB << pickWinner_s;
            end else begin
               stateNext_s = ST_IDLE;
            end
         end
         ST_GRANT: begin
            stateNext_s = ST_WAIT_BEGIN;
            cntNext_s   = cntInc_s;
         end
         ST_WAIT_BEGIN: begin
            if (bus.beginTransactionIn) begin
               stateNext_s = ST_BUSY;
               cntNext_s   = CNT_ZERO;
            end else if (!ownerReq_s || bus.endTransactionIn || (cnt_r >= BEGIN_LIMIT)) begin
               // Grant unused: release quietly, no error.
               stateNext_s = ST_IDLE;
               cntNext_s   = CNT_ZERO;
            end else begin
               cntNext_s = cntInc_s;
            end
         end
         ST_BUSY: begin
            // A real end beats a watchdog expiry in the same cycle.
            if (bus.endTransactionIn || bus.busErrorIn) begin
               stateNext_s = ST_IDLE;
               cntNext_s   = CNT_ZERO;
            end else if ((WATCHDOG_CYCLES != 0) && (cnt_r >= WD_LIMIT)) begin
               stateNext_s = ST_ABORT;
               cntNext_s   = CNT_ZERO;
            end else begin
               cntNext_s = cntInc_s;
            end
         end
         ST_ABORT: begin
            stateNext_s = ST_IDLE;
            cntNext_s   = CNT_ZERO;
         end
         default: begin
            stateNext_s = ST_IDLE;
            cntNext_s   = CNT_ZERO;
         end
      endcase
   end

   // State and registered outputs; outputs are derived from the next state.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_r     <= ST_IDLE;
         cnt_r       <= CNT_ZERO;
         pointer_r   <= PTR_RESET;
         busOwner_r  <= OWNER_ZERO;
         grant_r     <= GRANT_NONE;
         forceEnd_r  <= 1'b0;
         forceErr_r  <= 1'b0;
         busActive_r <= 1'b0;
      end else begin
         state_r     <= stateNext_s;
         cnt_r       <= cntNext_s;
         pointer_r   <= pointerNext_s;
         busOwner_r  <= ownerNext_s;
         grant_r     <= grantNext_s;
         forceEnd_r  <= (stateNext_s == ST_ABORT);
         forceErr_r  <= (stateNext_s == ST_ABORT);
         busActive_r <= (stateNext_s != ST_IDLE);
      end
   end

   assign bus.transactionGranted = grant_r;
   assign bus.endTransactionOut  = forceEnd_r;
   assign bus.busErrorOut        = forceErr_r;
   assign bus.busOwner           = busOwner_r;
   assign bus.busActive          = busActive_r;

endmodule

// File: tb/tb_bus_arbiter_rr.sv
// Directed scoreboard bench for bus_arbiter_rr (4 masters, begin timeout 16,
// watchdog 32). Stimulus queues the expected grant/abort/release events with
// their absolute cycle numbers; a negedge monitor pops and compares them.
module tb_bus_arbiter_rr;

   localparam int K_GRANT   = 0;
   localparam int K_ABORT   = 1;
   localparam int K_RELEASE = 2;

   typedef struct {
      string name;
      int    kind;
      int    cycle;
      int    value;
   } event_t;

   logic   clock;
   logic   reset;
   int     cycleCount;
   int     total;
   int     bad;
   logic   prevActive;
   event_t expQ[$];
   int     t;
   int     g;

   bus_arbiter_rr_if #(.NUM_MASTERS(4)) bus ();

   bus_arbiter_rr #(
      .NUM_MASTERS     (4),
      .BEGIN_TIMEOUT   (16),
      .WATCHDOG_CYCLES (32)
   ) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial cycleCount = 0;
   always @(posedge clock) cycleCount <= cycleCount + 1;

   task automatic checkVal(input string name, input int actual, input int expected);
      total = total + 1;
      if (actual != expected) begin
         bad = bad + 1;
         $display("FAIL %s: got %0d, want %0d (cycle %0d)", name, actual, expected, cycleCount);
      end
   endtask

   task automatic pushExp(input string name, input int kind, input int cycle, input int value);
      event_t e;
      e.name  = name;
      e.kind  = kind;
      e.cycle = cycle;
      e.value = value;
      expQ.push_back(e);
   endtask

   task automatic seeEvent(input int kind, input int value);
      event_t e;
      total = total + 1;
      if (expQ.size() == 0) begin
         bad = bad + 1;
         $display("FAIL unexpected_event: got kind=%0d cycle=%0d value=%0d, want none",
                  kind, cycleCount, value);
      end else begin
         e = expQ.pop_front();
         if (e.kind != kind || e.cycle != cycleCount || e.value != value) begin
            bad = bad + 1;
            $display("FAIL %s: got kind=%0d cycle=%0d value=%0d, want kind=%0d cycle=%0d value=%0d",
                     e.name, kind, cycleCount, value, e.kind, e.cycle, e.value);
         end
      end
   endtask

   // Monitor: turn DUT output activity into events and score them.
   initial prevActive = 1'b0;
   always @(negedge clock) begin
      if (bus.transactionGranted != 4'b0000) seeEvent(K_GRANT, int'(bus.transactionGranted));
      if (bus.endTransactionOut || bus.busErrorOut)
         seeEvent(K_ABORT, int'({bus.endTransactionOut, bus.busErrorOut}));
      if (prevActive && !bus.busActive) seeEvent(K_RELEASE, int'(bus.busOwner));
      prevActive <= bus.busActive;
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   task automatic checkIdleOutputs(input string tag);
      checkVal({tag, "_grant"},  int'(bus.transactionGranted), 0);
      checkVal({tag, "_endout"}, int'(bus.endTransactionOut),  0);
      checkVal({tag, "_errout"}, int'(bus.busErrorOut),        0);
      checkVal({tag, "_owner"},  int'(bus.busOwner),           0);
      checkVal({tag, "_active"}, int'(bus.busActive),          0);
   endtask

   task automatic doReset();
      reset = 1'b1;
      tick(1);
      reset = 1'b0;
   endtask

   initial begin
      total = 0;
      bad   = 0;
      reset = 1'b1;
      bus.requestTransaction = 4'b0000;
      bus.beginTransactionIn = 1'b0;
      bus.endTransactionIn   = 1'b0;
      bus.busErrorIn         = 1'b0;
      tick(3);
      checkIdleOutputs("reset");
      reset = 1'b0;
      tick(1);

      // Single request from master 2.
      doReset();
      t = cycleCount;
      bus.requestTransaction = 4'b0100;
      pushExp("single_grant",   K_GRANT,   t + 1, 4);
      pushExp("single_release", K_RELEASE, t + 9, 2);
      tick(3); bus.beginTransactionIn = 1'b1;
      tick(1); bus.beginTransactionIn = 1'b0;
      tick(4); bus.endTransactionIn = 1'b1;
      tick(1); bus.endTransactionIn = 1'b0; bus.requestTransaction = 4'b0000;
      checkVal("single_owner", int'(bus.busOwner), 2);
      tick(2);

      // Round robin with all four requesting.
      doReset();
      t = cycleCount;
      bus.requestTransaction = 4'b1111;
      g = t + 1;
      for (int k = 0; k < 5; k++) begin
         pushExp("rr_grant",   K_GRANT,   g + 7 * k,     1 << (k % 4));
         pushExp("rr_release", K_RELEASE, g + 7 * k + 6, k % 4);
      end
      tick(1);
      for (int k = 0; k < 5; k++) begin
         tick(2); bus.beginTransactionIn = 1'b1;
         tick(1); bus.beginTransactionIn = 1'b0;
         tick(2); bus.endTransactionIn = 1'b1;
         tick(1); bus.endTransactionIn = 1'b0;
         if (k == 4) bus.requestTransaction = 4'b0000;
         tick(1);
      end
      tick(2);

      // Begin timeout: master 1 never begins, master 2 waits.
      doReset();
      t = cycleCount;
      bus.requestTransaction = 4'b0110;
      pushExp("to_grant1",   K_GRANT,   t + 1,  2);
      pushExp("to_release1", K_RELEASE, t + 17, 1);
      pushExp("to_grant2",   K_GRANT,   t + 18, 4);
      pushExp("drop_release", K_RELEASE, t + 20, 2);
      tick(18); bus.requestTransaction = 4'b0000;
      tick(4);

      // Watchdog expiry.
      doReset();
      t = cycleCount;
      bus.requestTransaction = 4'b0001;
      pushExp("wd_grant",   K_GRANT,   t + 1,  1);
      pushExp("wd_abort",   K_ABORT,   t + 36, 3);
      pushExp("wd_release", K_RELEASE, t + 37, 0);
      tick(3); bus.beginTransactionIn = 1'b1;
      tick(1); bus.beginTransactionIn = 1'b0; bus.requestTransaction = 4'b0000;
      tick(34);

      // End arriving in the watchdog expiry cycle.
      doReset();
      t = cycleCount;
      bus.requestTransaction = 4'b0001;
      pushExp("wdend_grant",   K_GRANT,   t + 1,  1);
      pushExp("wdend_release", K_RELEASE, t + 36, 0);
      tick(3); bus.beginTransactionIn = 1'b1;
      tick(1); bus.beginTransactionIn = 1'b0; bus.requestTransaction = 4'b0000;
      tick(31); bus.endTransactionIn = 1'b1;
      tick(1); bus.endTransactionIn = 1'b0;
      tick(2);

      // Slave error during BUSY; master 0 keeps requesting.
      doReset();
      t = cycleCount;
      bus.requestTransaction = 4'b0111;
      pushExp("err_grant0",   K_GRANT,   t + 1,  1);
      pushExp("err_release",  K_RELEASE, t + 7,  0);
      pushExp("err_grant1",   K_GRANT,   t + 8,  2);
      pushExp("err_release1", K_RELEASE, t + 10, 1);
      tick(3); bus.beginTransactionIn = 1'b1;
      tick(1); bus.beginTransactionIn = 1'b0;
      tick(2); bus.busErrorIn = 1'b1;
      tick(1); bus.busErrorIn = 1'b0;
      tick(1); bus.requestTransaction = 4'b0000;
      tick(4);

      // Reset while master 3 owns the bus.
      doReset();
      t = cycleCount;
      bus.requestTransaction = 4'b1000;
      pushExp("rst_grant3",   K_GRANT,   t + 1,  8);
      pushExp("rst_release",  K_RELEASE, t + 7,  0);
      pushExp("rst_grant0",   K_GRANT,   t + 8,  1);
      pushExp("rst_release0", K_RELEASE, t + 10, 0);
      tick(3); bus.beginTransactionIn = 1'b1;
      tick(1); bus.beginTransactionIn = 1'b0; bus.requestTransaction = 4'b0000;
      tick(2); reset = 1'b1;
      tick(1);
      checkIdleOutputs("midreset");
      reset = 1'b0;
      bus.requestTransaction = 4'b1001;
      tick(1); bus.requestTransaction = 4'b0000;
      tick(4);

      // Drain, then count anything still expected as missed.
      for (int i = 0; i < 50 && expQ.size() != 0; i++) tick(1);
      while (expQ.size() != 0) begin
         event_t e;
         e = expQ.pop_front();
         total = total + 1;
         bad   = bad + 1;
         $display("FAIL %s: got no event, want kind=%0d cycle=%0d value=%0d",
                  e.name, e.kind, e.cycle, e.value);
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
